// File: rtl/fetcher_pkg.sv
// Shared widths, opcodes and FSM encoding for the fetch stage.
package fetcher_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FET_FETCH = 2'd0,
        FET_HOLD  = 2'd1,
        FET_DROP  = 2'd2
    } fet_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode: extracts J/B immediates and picks next PC and taken hint.
module fetch_predecode
    import fetcher_pkg::*;
(
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            bp_pred,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_jump
);

    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_b;
    logic [6:0]      w_opcode;

    assign w_opcode = inst[6:0];
    assign w_imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    // JALR falls through to pc+4; the ROB redirects it later.
    always_comb begin
        next_pc   = pc + XLEN'(4);
        pred_jump = 1'b0;
        if (w_opcode == OPC_JAL) begin
            next_pc   = pc + w_imm_j;
            pred_jump = 1'b1;
        end else if (w_opcode == OPC_BRANCH) begin
            pred_jump = bp_pred;
            if (bp_pred) begin
                next_pc = pc + w_imm_b;
            end
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the fetch PC, requests icache words and pushes them to the IQ.
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] fet_pc,
    input  logic            bp_pred,
    output logic            fet_icache_valid,
    output logic [XLEN-1:0] fet_icache_addr,
    input  logic            icache_fet_ready,
    input  logic [31:0]     icache_fet_inst,
    input  logic            iq_full,
    output logic            fet_iq_valid,
    output logic [31:0]     fet_iq_inst,
    output logic [XLEN-1:0] fet_iq_pc,
    output logic            fet_iq_pred_jump,
    input  logic            rob_flush,
    input  logic [XLEN-1:0] rob_flush_pc
);

    fet_state_e      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_hold_valid;
    logic [31:0]     r_hold_inst;
    logic            r_hold_pred;
    logic [XLEN-1:0] r_hold_next_pc;
    logic            r_iq_valid;
    logic [31:0]     r_iq_inst;
    logic [XLEN-1:0] r_iq_pc;
    logic            r_iq_pred;

    logic [XLEN-1:0] w_next_pc;
    logic            w_pred_jump;

    fetch_predecode u_predecode (
        .inst      (icache_fet_inst),
        .pc        (r_pc),
        .bp_pred   (bp_pred),
        .next_pc   (w_next_pc),
        .pred_jump (w_pred_jump)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= FET_FETCH;
            r_pc           <= RESET_PC;
            r_hold_valid   <= 1'b0;
            r_hold_inst    <= '0;
            r_hold_pred    <= 1'b0;
            r_hold_next_pc <= '0;
            r_iq_valid     <= 1'b0;
            r_iq_inst      <= '0;
            r_iq_pc        <= '0;
            r_iq_pred      <= 1'b0;
        end else begin
            r_iq_valid <= 1'b0;
            if (rob_flush) begin
                r_pc         <= rob_flush_pc;
                r_hold_valid <= 1'b0;
                // An outstanding request must be drained before fetching the new target.
                case (r_state)
                    FET_FETCH: r_state <= icache_fet_ready ? FET_FETCH : FET_DROP;
                    FET_DROP:  r_state <= icache_fet_ready ? FET_FETCH : FET_DROP;
                    default:   r_state <= FET_FETCH;
                endcase
            end else begin
                case (r_state)
                    FET_FETCH: begin
                        if (icache_fet_ready) begin
                            if (!iq_full) begin
                                r_iq_valid <= 1'b1;
                                r_iq_inst  <= icache_fet_inst;
                                r_iq_pc    <= r_pc;
                                r_iq_pred  <= w_pred_jump;
                                r_pc       <= w_next_pc;
                            end else begin
                                r_hold_valid   <= 1'b1;
                                r_hold_inst    <= icache_fet_inst;
                                r_hold_pred    <= w_pred_jump;
                                r_hold_next_pc <= w_next_pc;
                                r_state        <= FET_HOLD;
                            end
                        end
                    end
                    FET_HOLD: begin
                        if (!iq_full) begin
                            r_iq_valid   <= r_hold_valid;
                            r_iq_inst    <= r_hold_inst;
                            r_iq_pc      <= r_pc;
                            r_iq_pred    <= r_hold_pred;
                            r_pc         <= r_hold_next_pc;
                            r_hold_valid <= 1'b0;
                            r_state      <= FET_FETCH;
                        end
                    end
                    FET_DROP: begin
                        if (icache_fet_ready) begin
                            r_state <= FET_FETCH;
                        end
                    end
                    default: r_state <= FET_FETCH;
                endcase
            end
        end
    end

    assign fet_pc           = r_pc;
    assign fet_icache_addr  = r_pc;
    assign fet_icache_valid = (r_state == FET_FETCH);
    assign fet_iq_valid     = r_iq_valid;
    assign fet_iq_inst      = r_iq_inst;
    assign fet_iq_pc        = r_iq_pc;
    assign fet_iq_pred_jump = r_iq_pred;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: predecode targets, IQ stalls, flush/drop handling and async reset.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0100_006F;
    localparam logic [31:0] BEQ  = 32'hFE00_0EE3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] fet_pc;
    logic            bp_pred;
    logic            fet_icache_valid;
    logic [XLEN-1:0] fet_icache_addr;
    logic            icache_fet_ready;
    logic [31:0]     icache_fet_inst;
    logic            iq_full;
    logic            fet_iq_valid;
    logic [31:0]     fet_iq_inst;
    logic [XLEN-1:0] fet_iq_pc;
    logic            fet_iq_pred_jump;
    logic            rob_flush;
    logic [XLEN-1:0] rob_flush_pc;

    int n_vec = 0;
    int n_err = 0;

    fetcher dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fet_pc           (fet_pc),
        .bp_pred          (bp_pred),
        .fet_icache_valid (fet_icache_valid),
        .fet_icache_addr  (fet_icache_addr),
        .icache_fet_ready (icache_fet_ready),
        .icache_fet_inst  (icache_fet_inst),
        .iq_full          (iq_full),
        .fet_iq_valid     (fet_iq_valid),
        .fet_iq_inst      (fet_iq_inst),
        .fet_iq_pc        (fet_iq_pc),
        .fet_iq_pred_jump (fet_iq_pred_jump),
        .rob_flush        (rob_flush),
        .rob_flush_pc     (rob_flush_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One icache response accepted with the IQ free; checks the push and the next request.
    task automatic respond(input string tag, input logic [31:0] inst, input logic bp,
                           input logic [31:0] exp_pc, input logic exp_pred,
                           input logic [31:0] exp_next);
        icache_fet_ready = 1'b1;
        icache_fet_inst  = inst;
        bp_pred          = bp;
        tick();
        icache_fet_ready = 1'b0;
        icache_fet_inst  = '0;
        bp_pred          = 1'b0;
        check({tag, ".valid"}, {31'd0, fet_iq_valid}, 32'd1);
        check({tag, ".inst"}, fet_iq_inst, inst);
        check({tag, ".pc"}, fet_iq_pc, exp_pc);
        check({tag, ".pred"}, {31'd0, fet_iq_pred_jump}, {31'd0, exp_pred});
        check({tag, ".addr"}, fet_icache_addr, exp_next);
        check({tag, ".req"}, {31'd0, fet_icache_valid}, 32'd1);
        tick();
        check({tag, ".single"}, {31'd0, fet_iq_valid}, 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bp_pred          = 1'b0;
        icache_fet_ready = 1'b0;
        icache_fet_inst  = '0;
        iq_full          = 1'b0;
        rob_flush        = 1'b0;
        rob_flush_pc     = '0;
        #2;
        check("rst.pc", fet_pc, 32'h0);
        check("rst.iqv", {31'd0, fet_iq_valid}, 32'd0);
        check("rst.iqpc", fet_iq_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        check("rst.req", {31'd0, fet_icache_valid}, 32'd1);

        respond("addi0", ADDI, 1'b0, 32'h00, 1'b0, 32'h04);
        respond("addi4", ADDI, 1'b1, 32'h04, 1'b0, 32'h08);
        respond("jal8", JAL, 1'b0, 32'h08, 1'b1, 32'h18);
        respond("addi18", ADDI, 1'b0, 32'h18, 1'b0, 32'h1C);
        respond("addi1c", ADDI, 1'b0, 32'h1C, 1'b0, 32'h20);
        respond("beqT", BEQ, 1'b1, 32'h20, 1'b1, 32'h1C);
        respond("addi1c_b", ADDI, 1'b0, 32'h1C, 1'b0, 32'h20);
        respond("beqN", BEQ, 1'b0, 32'h20, 1'b0, 32'h24);

        // IQ full for three cycles starting with the response cycle.
        iq_full          = 1'b1;
        icache_fet_ready = 1'b1;
        icache_fet_inst  = JAL;
        tick();
        icache_fet_ready = 1'b0;
        icache_fet_inst  = '0;
        for (int i = 0; i < 2; i++) begin
            check("hold.nopush", {31'd0, fet_iq_valid}, 32'd0);
            check("hold.noreq", {31'd0, fet_icache_valid}, 32'd0);
            check("hold.pc", fet_pc, 32'h24);
            tick();
        end
        check("hold.nopush3", {31'd0, fet_iq_valid}, 32'd0);
        iq_full = 1'b0;
        tick();
        check("hold.push", {31'd0, fet_iq_valid}, 32'd1);
        check("hold.inst", fet_iq_inst, JAL);
        check("hold.iqpc", fet_iq_pc, 32'h24);
        check("hold.pred", {31'd0, fet_iq_pred_jump}, 32'd1);
        check("hold.next", fet_icache_addr, 32'h34);
        check("hold.req", {31'd0, fet_icache_valid}, 32'd1);
        tick();
        check("hold.single", {31'd0, fet_iq_valid}, 32'd0);

        // Flush with request outstanding: late response is discarded.
        rob_flush    = 1'b1;
        rob_flush_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        check("drop.noreq", {31'd0, fet_icache_valid}, 32'd0);
        check("drop.pc", fet_pc, 32'h100);
        tick();
        icache_fet_ready = 1'b1;
        icache_fet_inst  = JAL;
        tick();
        icache_fet_ready = 1'b0;
        check("drop.nopush", {31'd0, fet_iq_valid}, 32'd0);
        check("drop.addr", fet_icache_addr, 32'h100);
        check("drop.req", {31'd0, fet_icache_valid}, 32'd1);

        // Flush in the same cycle as the response.
        icache_fet_ready = 1'b1;
        icache_fet_inst  = ADDI;
        rob_flush        = 1'b1;
        rob_flush_pc     = 32'h200;
        tick();
        icache_fet_ready = 1'b0;
        rob_flush        = 1'b0;
        check("fsame.nopush", {31'd0, fet_iq_valid}, 32'd0);
        check("fsame.addr", fet_icache_addr, 32'h200);
        check("fsame.req", {31'd0, fet_icache_valid}, 32'd1);

        // Flush during HOLD with IQ space freeing the same cycle.
        iq_full          = 1'b1;
        icache_fet_ready = 1'b1;
        tick();
        icache_fet_ready = 1'b0;
        iq_full          = 1'b0;
        rob_flush        = 1'b1;
        rob_flush_pc     = 32'hFFFF_FFFC;
        tick();
        rob_flush = 1'b0;
        check("fhold.nopush", {31'd0, fet_iq_valid}, 32'd0);
        check("fhold.addr", fet_icache_addr, 32'hFFFF_FFFC);
        check("fhold.req", {31'd0, fet_icache_valid}, 32'd1);
        tick();
        check("fhold.nopush2", {31'd0, fet_iq_valid}, 32'd0);

        respond("wrap", ADDI, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Push, then async reset while the next request is outstanding.
        respond("pre", ADDI, 1'b0, 32'h0, 1'b0, 32'h4);
        icache_fet_ready = 1'b1;
        icache_fet_inst  = BEQ;
        bp_pred          = 1'b1;
        tick();
        icache_fet_ready = 1'b0;
        bp_pred          = 1'b0;
        check("arst.pre", fet_iq_pc, 32'h4);
        rst_n = 1'b0;
        #1;
        check("arst.iqv", {31'd0, fet_iq_valid}, 32'd0);
        check("arst.inst", fet_iq_inst, 32'h0);
        check("arst.iqpc", fet_iq_pc, 32'h0);
        check("arst.pred", {31'd0, fet_iq_pred_jump}, 32'd0);
        check("arst.pc", fet_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        respond("restart", ADDI, 1'b0, 32'h0, 1'b0, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
